// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_if
// Description : CU-side request/response and external memory bus signals
//               for the memory access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    // CU request side
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;
    logic                  bus_err;

    // External memory bus side
    logic [DATA_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_rd;
    logic                  ext_wr;
    logic [DATA_WIDTH-1:0] ext_rdata;
    logic                  ext_ack;

    // The sequencer itself
    modport slave (
        input  mem_rd, mem_wr, addr, wr_data, ext_rdata, ext_ack,
        output rd_data, ready, bus_err, ext_addr, ext_wdata, ext_rd, ext_wr
    );

    // The environment: CU plus memory bus agent
    modport master (
        output mem_rd, mem_wr, addr, wr_data, ext_rdata, ext_ack,
        input  rd_data, ready, bus_err, ext_addr, ext_wdata, ext_rd, ext_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Memory access sequencer. Turns a held CU read/write request
//               into one handshaked external bus transaction with wait
//               states and a timeout, returning a one-cycle ready pulse
//               (with bus_err on failure). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int TIMEOUT    = 16,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_bus_ctrl_if.slave  bus
);

    // S_REJECT is a dead cycle for an illegal (read+write) request so that
    // its ready pulse lands with the same two-cycle latency as a zero-wait
    // access; it never drives a strobe.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_DONE   = 3'd2,
        S_ERROR  = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_is_read;
    logic [7:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_ext_addr;
    logic [DATA_WIDTH-1:0] r_ext_wdata;
    logic                  r_ready;
    logic                  r_bus_err;
    logic                  r_ext_rd;
    logic                  r_ext_wr;

    logic                  w_accept;
    logic                  w_ack_hit;
    logic                  w_next_is_read;

    assign bus.rd_data   = r_rd_data;
    assign bus.ready     = r_ready;
    assign bus.bus_err   = r_bus_err;
    assign bus.ext_addr  = r_ext_addr;
    assign bus.ext_wdata = r_ext_wdata;
    assign bus.ext_rd    = r_ext_rd;
    assign bus.ext_wr    = r_ext_wr;

    // Next-state selection and one-hot-ish event decode
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_ack_hit      = 1'b0;
        w_next_is_read = r_is_read;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_rd ^ bus.mem_wr) begin
                    w_accept       = 1'b1;
                    w_next_is_read = bus.mem_rd;
                    w_state_next   = S_ACCESS;
                end else if (bus.mem_rd && bus.mem_wr) begin
                    w_state_next = S_REJECT;
                end
            end
            S_ACCESS: begin
                // Ack wins over timeout on the same edge
                if (bus.ext_ack) begin
                    w_ack_hit    = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_next = S_ERROR;
                end
            end
            S_REJECT: w_state_next = S_ERROR;
            S_DONE:   w_state_next = S_IDLE;
            S_ERROR:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered datapath and outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_read   <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_rd_data   <= '0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ready     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_ext_rd    <= 1'b0;
            r_ext_wr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ext_addr  <= bus.addr;
                r_ext_wdata <= bus.wr_data;
                r_is_read   <= bus.mem_rd;
            end
            if ((r_state == S_ACCESS) && (w_state_next == S_ACCESS)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (w_ack_hit && r_is_read) begin
                r_rd_data <= bus.ext_rdata;
            end
            r_ext_rd  <= (w_state_next == S_ACCESS) &&  w_next_is_read;
            r_ext_wr  <= (w_state_next == S_ACCESS) && !w_next_is_read;
            r_ready   <= (w_state_next == S_DONE) || (w_state_next == S_ERROR);
            r_bus_err <= (w_state_next == S_ERROR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench for mem_bus_ctrl: directed vector table,
//               reset-mid-access sequence and randomized transactions
//               compared against an outcome-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int c_TIMEOUT = 16;
    localparam int c_DW      = 32;
    localparam int c_NEVER   = 255;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [31:0] model_rd;

    mem_bus_ctrl_if #(.DATA_WIDTH(c_DW)) bus ();

    mem_bus_ctrl #(
        .TIMEOUT    (c_TIMEOUT),
        .DATA_WIDTH (c_DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          k;
        int          exp_s;
        int          exp_l;
        bit          exp_e;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Outcome of one request from the rules alone: k is the number of wait
    // cycles before ack (>= TIMEOUT means the ack never arrives in time).
    function automatic void model(input bit rd, input bit wr, input int k,
                                  input logic [31:0] rdat, inout logic [31:0] mrd,
                                  output int s, output int l, output bit e);
        if (rd && wr) begin
            s = 0; l = 2; e = 1'b1;
        end else if (k < c_TIMEOUT) begin
            s = k + 1; l = k + 2; e = 1'b0;
            if (rd) mrd = rdat;
        end else begin
            s = c_TIMEOUT; l = c_TIMEOUT + 1; e = 1'b1;
        end
    endfunction

    // Acts as CU and bus agent for one request. lat counts cycles from the
    // request edge (cycle 1 = right after it) to the cycle showing ready.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat,
                           input int k, input bit junk,
                           output int strobes, output int lat, output bit err,
                           output int bad, output int extra);
        bit done;
        strobes = 0; lat = 0; err = 1'b0; bad = 0; extra = 0; done = 1'b0;
        @(negedge clk);
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.addr      = a;
        bus.wr_data   = wd;
        bus.ext_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ext_rdata = $urandom;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk);
            #1;
            if (bus.bus_err && !bus.ready) bad++;
            if (bus.ext_rd || bus.ext_wr) begin
                strobes++;
                if (bus.ext_rd !== rd || bus.ext_wr !== wr) bad++;
                if (bus.ext_addr !== a || bus.ext_wdata !== wd) bad++;
                bus.ext_ack   = (strobes == k + 1);
                bus.ext_rdata = (strobes == k + 1) ? rdat : $urandom;
                if (junk) begin
                    bus.addr    = $urandom;
                    bus.wr_data = $urandom;
                end
            end else begin
                bus.ext_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.ext_rdata = $urandom;
            end
            if (bus.ready) begin
                lat  = c;
                err  = bus.bus_err;
                done = 1'b1;
            end
        end
        // Request held through the edge that samples ready, then dropped
        @(posedge clk);
        #1;
        if (bus.ready || bus.ext_rd || bus.ext_wr) extra++;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.ext_ack = 1'b0;
        @(posedge clk);
        #1;
        if (bus.ready || bus.ext_rd || bus.ext_wr) extra++;
    endtask

    task automatic check_txn(input string tag, input int s, input int l, input bit e,
                             input int bad, input int extra,
                             input int exp_s, input int exp_l, input bit exp_e,
                             input logic [31:0] exp_rd);
        check({tag, ".strobes"},  32'(s), 32'(exp_s));
        check({tag, ".latency"},  32'(l), 32'(exp_l));
        check({tag, ".bus_err"},  32'(e), 32'(exp_e));
        check({tag, ".rd_data"},  bus.rd_data, exp_rd);
        check({tag, ".stable"},   32'(bad), 32'd0);
        check({tag, ".single"},   32'(extra), 32'd0);
    endtask

    initial begin
        int s, l, bad, extra, es, el;
        bit e, ee;
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0,       1,  2,  1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0,        3,       4,  5,  1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'h11111111, c_NEVER, 16, 17, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 15,      16, 17, 1'b0, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b1, 32'h50, 32'h99,       32'h22222222, 0,       0,  2,  1'b1, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b1, 32'h60, 32'hA5A5A5A5, 32'h0,        16,      16, 17, 1'b1, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'h70, 32'h0,        32'h00005A5A, 1,       2,  3,  1'b0, 32'h00005A5A};

        rst           = 1'b1;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.addr      = '0;
        bus.wr_data   = '0;
        bus.ext_rdata = '0;
        bus.ext_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rd_data",   bus.rd_data, 32'h0);
        check("reset.ext_addr",  bus.ext_addr, 32'h0);
        check("reset.ext_wdata", bus.ext_wdata, 32'h0);
        check("reset.flags", {28'h0, bus.ready, bus.bus_err, bus.ext_rd, bus.ext_wr}, 32'h0);
        rst = 1'b0;

        // Ack and junk read data while idle must be ignored
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 32'hBADBAD00;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ack.rd_data", bus.rd_data, 32'h0);
        check("idle_ack.ready",   32'(bus.ready), 32'd0);
        bus.ext_ack = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].rdat,
                    vecs[i].k, 1'b0, s, l, e, bad, extra);
            check_txn($sformatf("vec%0d", i), s, l, e, bad, extra,
                      vecs[i].exp_s, vecs[i].exp_l, vecs[i].exp_e, vecs[i].exp_rd);
        end

        // Reset during the 2nd ACCESS cycle of a read
        @(negedge clk);
        bus.mem_rd = 1'b1;
        bus.addr   = 32'h80;
        @(posedge clk);
        #1;
        check("rst_mid.strobe_on", 32'(bus.ext_rd), 32'd1);
        @(posedge clk);
        #1;
        check("rst_mid.strobe_2nd", 32'(bus.ext_rd), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.ext_rd",  32'(bus.ext_rd), 32'd0);
        check("rst_mid.rd_data", bus.rd_data, 32'h0);
        check("rst_mid.ready",   32'(bus.ready), 32'd0);
        rst        = 1'b0;
        bus.mem_rd = 1'b0;
        e = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.ready || bus.ext_rd) e = 1'b1;
        end
        check("rst_mid.quiet", 32'(e), 32'd0);
        model_rd = 32'h0;
        model(1'b1, 1'b0, 0, 32'h13572468, model_rd, es, el, ee);
        run_txn(1'b1, 1'b0, 32'h84, 32'h0, 32'h13572468, 0, 1'b0, s, l, e, bad, extra);
        check_txn("rst_mid.after", s, l, e, bad, extra, es, el, ee, model_rd);

        // Randomized requests with junk ack outside ACCESS and input churn
        for (int i = 0; i < 30; i++) begin
            bit          rd, wr;
            int          k;
            logic [31:0] a, wd, rdat;
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 9) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            k    = $urandom_range(0, 20);
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            model(rd, wr, k, rdat, model_rd, es, el, ee);
            run_txn(rd, wr, a, wd, rdat, k, 1'b1, s, l, e, bad, extra);
            check_txn($sformatf("rand%0d", i), s, l, e, bad, extra, es, el, ee, model_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory access sequencer between the control unit and the external memory bus. It takes the CU's `mem_rd`/`mem_wr` strobes, the address and the write data. It runs one handshaked bus transaction with variable wait states and a timeout, then returns read data plus a one-cycle `ready` (and `bus_err` on failure). The CU holds its request until it sees `ready`.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS without `ext_ack` before the transaction aborts; legal range 1..255.
- DATA_WIDTH, 32: data and address width.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_rd  in  1  read request from CU; held until ready
- mem_wr  in  1  write request from CU; held until ready
- addr  in  DATA_WIDTH  access address (MAR value)
- wr_data  in  DATA_WIDTH  write data (MDR value)
- rd_data  out  DATA_WIDTH  last successfully read word
- ready  out  1  one-cycle pulse: transaction finished
- bus_err  out  1  one-cycle pulse with ready: transaction failed
- ext_addr  out  DATA_WIDTH  bus address
- ext_wdata  out  DATA_WIDTH  bus write data
- ext_rd  out  1  bus read strobe
- ext_wr  out  1  bus write strobe
- ext_rdata  in  DATA_WIDTH  bus read data, valid with ext_ack
- ext_ack  in  1  bus completion

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; `rd_data`, `ext_addr`, `ext_wdata` = 0; `ready`, `bus_err`, `ext_rd`, `ext_wr` = 0; wait counter = 0.
- **IDLE:**
  - `mem_rd` xor `mem_wr` high at an edge: latch `addr`, `wr_data` and direction; go to ACCESS.
  - Both high: no bus activity; go to ERROR.
  - Neither high: stay in IDLE.
- **ACCESS:**
  - `ext_rd` (read) or `ext_wr` (write) = 1; `ext_addr`/`ext_wdata` hold the latched values and stay stable for the whole state.
  - Counter clears on entry and increments every cycle without ack.
  - `ext_ack` sampled high: for reads, `rd_data` <= `ext_rdata`; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: go to ERROR.
  - Ack takes priority over timeout on the same edge.
- **DONE:** `ready` = 1 for exactly one cycle, strobes = 0, then IDLE.
- **ERROR:** `ready` = 1 and `bus_err` = 1 for one cycle, strobes = 0, `rd_data` unchanged, then IDLE.
- Latency:
  - Request sampled at edge N; strobe high during cycle N+1.
  - Ack sampled at edge N+1+k; `ready` high during cycle N+2+k, where k is the number of wait cycles (k = 0 when ack arrives in the first ACCESS cycle).
  - Minimum request-to-ready is 2 cycles.
- CU contract: the CU drops its request on the edge where it samples `ready` = 1. The request is re-examined only in IDLE, one cycle after DONE/ERROR, so there is no double issue.
- `ext_ack` outside ACCESS is ignored.
- `addr`/`wr_data`/request changes during ACCESS are ignored; latched values are used.
- `rst` in any state: next edge forces the reset values, and strobes drop immediately on that edge. An in-flight transaction is abandoned and no `ready` is issued.
- `rd_data` holds its value between reads; writes never modify it.

Test Plan:
1. Zero-wait read: `mem_rd`=1, `addr`=0x10, `ext_ack` high in the first ACCESS cycle with `ext_rdata`=0xDEADBEEF. Required: `ext_rd`=1 and `ext_addr`=0x10 for 1 cycle; `ready` pulse 2 cycles after the request edge; `rd_data`=0xDEADBEEF; `bus_err`=0.
2. Write with 3 wait states: `mem_wr`=1, `addr`=0x20, `wr_data`=0x12345678, ack on the 4th ACCESS cycle. Required: `ext_wr` high exactly 4 cycles; `ext_wdata` stable at 0x12345678 throughout; single `ready` pulse; `rd_data` unchanged.
3. Timeout: read with no ack, TIMEOUT=16. Required: `ext_rd` high exactly 16 cycles, then `ready`=1 and `bus_err`=1 for one cycle; `rd_data` unchanged.
4. Ack on the timeout edge (ack in the 16th ACCESS cycle). Required: treated as success; `bus_err`=0; `rd_data` updated.
5. Illegal request: `mem_rd`=`mem_wr`=1. Required: no strobe ever asserted; `ready`/`bus_err` pulse 2 cycles after the request edge.
6. Reset mid-access: `rst`=1 during the 2nd ACCESS cycle of a read. Required: next edge gives `ext_rd`=0 and `rd_data`=0, with no `ready`. A new read after `rst` deasserts completes normally.
